ch_seq: RTL and testbench

Control-path sequencer for one SSDMA channel. It accepts a descriptor length and sequences the channel's source/destination FIFO datapath: it requests source words from the bus side, tracks source and destination FIFO occupancy, and presents empty/full/last status to the processing module. It also clears both FIFOs at descriptor start and reports completion. It sits beside the channel datapath and drives its `ss_start*`, `ss_end*`, `m_reset`, `m_src_empty`, `m_dst_full` and `m_last` signals.

---
 rtl/ch_seq_pkg.sv | 14 +
 rtl/ch_lvl_cnt.sv | 52 +++++
 rtl/ch_seq.sv | 178 +++++++++++++++++
 tb/tb_ch_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_seq_pkg.sv
// Shared definitions for the SSDMA channel sequencer: FSM encoding and
// descriptor length width.
package ch_seq_pkg;

    localparam int unsigned LenWidth = 24;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StClr  = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } ch_state_e;

endpackage

// File: rtl/ch_lvl_cnt.sv
// FIFO occupancy counter with legality-checked push/pop strobes. Illegal
// strobes are dropped and flagged on err for the current cycle.
module ch_lvl_cnt #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             push_allow,
    input  logic             pop,
    input  logic             pop_allow,
    output logic [Width-1:0] level,
    output logic             full,
    output logic             push_ok,
    output logic             pop_ok,
    output logic             err
);

    localparam logic [Width-1:0] DepthW = Width'(Depth);

    logic [Width-1:0] level_q, level_d;
    logic             empty;

    assign empty   = (level_q == '0);
    assign full    = (level_q == DepthW);
    assign push_ok = push & push_allow & ~full;
    assign pop_ok  = pop & pop_allow & ~empty;
    assign err     = (push & ~push_ok) | (pop & ~pop_ok);
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        if (clr) begin
            level_d = '0;
        end else if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/ch_seq.sv
// Control-path sequencer for one SSDMA channel. Define CH_SEQ_TIMEOUT_EN to
// enable the RUN-state progress watchdog (TIMEOUT cycles without a counted strobe).
module ch_seq
    import ch_seq_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 9
`ifdef CH_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 4096
`endif
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [LenWidth-1:0] dc0,
    input  logic                dc_valid,
    output logic                dc_ready,
    output logic                ss_start0,
    input  logic                ss_xfer0,
    output logic                ss_end0,
    output logic                ss_start1,
    input  logic                ss_xfer1,
    output logic                ss_end1,
    input  logic                m_src_getn,
    input  logic                m_dst_putn,
    output logic                m_src_empty,
    output logic                m_dst_full,
    output logic                m_last,
    output logic                m_reset,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned LvlW  = FIFO_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_WIDTH;

    ch_state_e state_q, state_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] src_in_q, src_in_d, src_out_q, src_out_d;
    logic [LenWidth-1:0] dst_in_q, dst_in_d, dst_out_q, dst_out_d;
    logic                err_q, err_d, ss_end0_q, ss_end1_q;
    logic [LvlW-1:0]     src_lvl, dst_lvl;
    logic src_full, src_push_ok, src_pop_ok, src_err;
    logic dst_full, dst_push_ok, dst_pop_ok, dst_err;
    logic run, accept, clr, tmo_hit, tmo_rst;

    assign run    = (state_q == StRun);
    assign accept = dc_valid & dc_ready;
    assign clr    = (state_q == StClr) | tmo_rst;

    ch_lvl_cnt #(.Width(LvlW), .Depth(DEPTH)) u_src_lvl (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_i),
        .clr        (clr),
        .push       (ss_xfer0),
        .push_allow (ss_start0),
        .pop        (~m_src_getn),
        .pop_allow  (run),
        .level      (src_lvl),
        .full       (src_full),
        .push_ok    (src_push_ok),
        .pop_ok     (src_pop_ok),
        .err        (src_err)
    );

    // Module pushes beyond the descriptor length are refused here.
    ch_lvl_cnt #(.Width(LvlW), .Depth(DEPTH)) u_dst_lvl (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_i),
        .clr        (clr),
        .push       (~m_dst_putn),
        .push_allow (run & (dst_in_q != len_q)),
        .pop        (ss_xfer1),
        .pop_allow  (run),
        .level      (dst_lvl),
        .full       (dst_full),
        .push_ok    (dst_push_ok),
        .pop_ok     (dst_pop_ok),
        .err        (dst_err)
    );

`ifdef CH_SEQ_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_rst_q, any_ok;

    assign any_ok    = src_push_ok | src_pop_ok | dst_push_ok | dst_pop_ok;
    assign tmo_hit   = run & ~any_ok & (tmo_cnt_q == TIMEOUT - 1);
    assign tmo_cnt_d = (run && !any_ok) ? tmo_cnt_q + 32'd1 : 32'd0;
    assign tmo_rst   = tmo_rst_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            tmo_cnt_q <= '0;
            tmo_rst_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_rst_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_rst = 1'b0;
`endif

    always_comb begin
        src_in_d  = src_in_q;
        src_out_d = src_out_q;
        dst_in_d  = dst_in_q;
        dst_out_d = dst_out_q;
        if (clr) begin
            src_in_d  = '0;
            src_out_d = '0;
            dst_in_d  = '0;
            dst_out_d = '0;
        end else begin
            if (src_push_ok) src_in_d  = src_in_q + 1'b1;
            if (src_pop_ok)  src_out_d = src_out_q + 1'b1;
            if (dst_push_ok) dst_in_d  = dst_in_q + 1'b1;
            if (dst_pop_ok)  dst_out_d = dst_out_q + 1'b1;
        end
        len_d = accept ? dc0 : len_q;
        err_d = accept ? 1'b0 : (err_q | src_err | dst_err | tmo_hit);
    end

    // Completion looks at the next dst_out so done lands the cycle after the last drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (dc_valid) state_d = StClr;
            StClr:   state_d = (len_q == '0) ? StDone : StRun;
            StRun: begin
                if (dst_out_d == len_q) state_d = StDone;
                else if (tmo_hit)       state_d = StIdle;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= StIdle;
            len_q     <= '0;
            src_in_q  <= '0;
            src_out_q <= '0;
            dst_in_q  <= '0;
            dst_out_q <= '0;
            err_q     <= 1'b0;
            ss_end0_q <= 1'b0;
            ss_end1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            src_in_q  <= src_in_d;
            src_out_q <= src_out_d;
            dst_in_q  <= dst_in_d;
            dst_out_q <= dst_out_d;
            err_q     <= err_d;
            ss_end0_q <= src_push_ok & (src_in_q + 1'b1 == len_q);
            ss_end1_q <= dst_pop_ok & (dst_out_q + 1'b1 == len_q);
        end
    end

    assign dc_ready    = (state_q == StIdle);
    assign busy        = ~dc_ready;
    assign done        = (state_q == StDone);
    assign err         = err_q;
    assign ss_end0     = ss_end0_q;
    assign ss_end1     = ss_end1_q;
    assign ss_start0   = run & (src_in_q != len_q) & ~src_full;
    assign ss_start1   = run & (dst_lvl != '0) & (dst_out_q != len_q);
    // Held low during reset so every status output reads 0 until release.
    assign m_src_empty = wb_rst_i & (src_lvl == '0);
    assign m_dst_full  = dst_full;
    assign m_last      = (src_lvl != '0) & (src_out_q == len_q - 1'b1);
    assign m_reset     = ~wb_rst_i | (state_q == StClr) | tmo_rst;

endmodule

// File: tb/tb_ch_seq.sv
// Scoreboard bench for ch_seq: stimulus queues per-descriptor expectations, a
// negedge bus/module model drives strobes and checks end/done/last events.
module tb_ch_seq;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic [23:0] dc0 = '0;
    logic        dc_valid = 1'b0;
    logic        dc_ready, ss_start0, ss_end0, ss_start1, ss_end1;
    logic        ss_xfer0 = 1'b0, ss_xfer1 = 1'b0;
    logic        m_src_getn = 1'b1, m_dst_putn = 1'b1;
    logic        m_src_empty, m_dst_full, m_last, m_reset, busy, done, err;

    always #5 clk = ~clk;

    ch_seq #(
        .FIFO_WIDTH(9)
`ifdef CH_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .dc0         (dc0),
        .dc_valid    (dc_valid),
        .dc_ready    (dc_ready),
        .ss_start0   (ss_start0),
        .ss_xfer0    (ss_xfer0),
        .ss_end0     (ss_end0),
        .ss_start1   (ss_start1),
        .ss_xfer1    (ss_xfer1),
        .ss_end1     (ss_end1),
        .m_src_getn  (m_src_getn),
        .m_dst_putn  (m_dst_putn),
        .m_src_empty (m_src_empty),
        .m_dst_full  (m_dst_full),
        .m_last      (m_last),
        .m_reset     (m_reset),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        int len;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    int   cyc = 0, x0 = 0, x1 = 0, pops = 0, e0 = 0, e1 = 0;
    int   last_x0 = 0, last_x1 = 0, last_act = 0, acc_cyc = 0;
    int   x0_lim = 1 << 30;
    bit   bus0_en = 0, bus1_en = 0, mod_en = 0, force_pop = 0;
    bit   drv_acc = 0, drv_x0 = 0, drv_x1 = 0, drv_pop = 0;

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Bus and module model plus monitor; runs on negedge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!wb_rst_i) begin
            x0 = 0; x1 = 0; pops = 0; e0 = 0; e1 = 0;
            drv_acc = 0; drv_x0 = 0; drv_x1 = 0; drv_pop = 0;
            ss_xfer0 = 0; ss_xfer1 = 0; m_src_getn = 1; m_dst_putn = 1;
        end else begin
            if (drv_acc) begin
                x0 = 0; x1 = 0; pops = 0; e0 = 0; e1 = 0; acc_cyc = cyc;
            end
            if (drv_x0) begin x0++; last_x0 = cyc; end
            if (drv_x1) begin x1++; last_x1 = cyc; end
            if (drv_pop) pops++;
            if (drv_x0 || drv_x1 || drv_pop) last_act = cyc;
            if (ss_end0) begin
                e0++;
                chk("end0_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk("end0_words", x0, exp_q[0].len);
                    chk("end0_latency", cyc, last_x0);
                end
            end
            if (ss_end1) begin
                e1++;
                chk("end1_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk("end1_words", x1, exp_q[0].len);
                    chk("end1_latency", cyc, last_x1);
                end
            end
            if (done) begin
                chk("done_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_src_words", x0, e.len);
                    chk("done_dst_words", x1, e.len);
                    chk("done_pops", pops, e.len);
                    chk("done_err", err, e.err);
                    chk("done_end0_pulses", e0, (e.len > 0) ? 1 : 0);
                    chk("done_end1_pulses", e1, (e.len > 0) ? 1 : 0);
                    chk("done_latency", cyc, (e.len > 0) ? last_x1 : acc_cyc + 1);
                end
            end
            drv_acc  = dc_valid & dc_ready;
            drv_x0   = bus0_en & ss_start0 & (x0 < x0_lim);
            drv_x1   = bus1_en & ss_start1;
            drv_pop  = mod_en & ~m_src_empty & ~m_dst_full;
            ss_xfer0 = drv_x0;
            ss_xfer1 = drv_x1;
            if (drv_pop && exp_q.size() > 0) chk("m_last", m_last, pops == exp_q[0].len - 1);
            m_src_getn = ~(drv_pop | force_pop);
            m_dst_putn = ~drv_pop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Returns in the CLR cycle of the accepted descriptor.
    task automatic send(input int len, input bit err_exp, input bit expect_done);
        dc0 = len[23:0];
        dc_valid = 1'b1;
        if (expect_done) exp_q.push_back('{len: len, err: err_exp});
        tick();
        dc_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_complete"}, exp_q.size(), 0);
        exp_q.delete();
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dc_ready"}, dc_ready, 1);
        chk({tag, "_m_reset"}, m_reset, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ss_start0"}, ss_start0, 0);
        chk({tag, "_ss_start1"}, ss_start1, 0);
        chk({tag, "_ss_end0"}, ss_end0, 0);
        chk({tag, "_ss_end1"}, ss_end1, 0);
        chk({tag, "_m_src_empty"}, m_src_empty, 0);
        chk({tag, "_m_dst_full"}, m_dst_full, 0);
        chk({tag, "_m_last"}, m_last, 0);
    endtask

    initial begin
        #3;
        chk_reset_outputs("rst");
        tick();
        tick();
        wb_rst_i = 1'b1;
        tick();
        chk("post_rst_m_reset", m_reset, 0);
        chk("post_rst_dc_ready", dc_ready, 1);

        // len=4, everyone always ready
        bus0_en = 1; bus1_en = 1; mod_en = 1;
        send(4, 0, 1);
        chk("len4_clr_m_reset", m_reset, 1);
        chk("len4_clr_busy", busy, 1);
        chk("len4_clr_start0", ss_start0, 0);
        tick();
        chk("len4_run_start0", ss_start0, 1);
        wait_done("len4", 100);
        chk("len4_idle_ready", dc_ready, 1);
        chk("len4_err", err, 0);

        // len=0: clear then straight to done
        send(0, 0, 1);
        chk("len0_m_reset", m_reset, 1);
        tick();
        chk("len0_done", done, 1);
        chk("len0_m_reset_off", m_reset, 0);
        chk("len0_start0", ss_start0, 0);
        wait_done("len0", 10);

        // len=600, module stalled until the source FIFO fills
        mod_en = 0;
        send(600, 0, 1);
        begin
            int n = 0;
            tick();
            while (ss_start0 && n < 1000) begin
                tick();
                n++;
            end
            chk("len600_stall_seen", n < 1000, 1);
        end
        repeat (3) tick();
        chk("len600_stall_start0", ss_start0, 0);
        chk("len600_stall_words", x0, 512);
        chk("len600_stall_empty", m_src_empty, 0);
        chk("len600_stall_pops", pops, 0);
        mod_en = 1;
        wait_done("len600", 3000);

        // illegal pop from empty source FIFO
        bus0_en = 0; mod_en = 0;
        send(3, 1, 1);
        tick();
        chk("pop_err_pre_err", err, 0);
        chk("pop_err_pre_empty", m_src_empty, 1);
        force_pop = 1;
        tick();
        force_pop = 0;
        chk("pop_err_err", err, 1);
        chk("pop_err_empty", m_src_empty, 1);
        chk("pop_err_last", m_last, 0);
        bus0_en = 1; mod_en = 1;
        wait_done("pop_err", 100);
        chk("pop_err_sticky", err, 1);
        send(2, 0, 1);
        chk("pop_err_cleared", err, 0);
        wait_done("after_err", 100);

        // asynchronous reset in the middle of a len=100 descriptor
        send(100, 0, 1);
        begin
            int n = 0;
            while (x0 < 10 && n < 200) begin
                tick();
                n++;
            end
            chk("midrst_progress", x0 >= 10, 1);
        end
        wb_rst_i = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        tick();
        tick();
        wb_rst_i = 1'b1;
        tick();
        send(3, 0, 1);
        wait_done("after_rst", 100);

`ifdef CH_SEQ_TIMEOUT_EN
        // bus stalls after two words; watchdog aborts without done
        x0_lim = 2;
        send(5, 0, 0);
        begin
            int n = 0;
            while (busy && n < 100) begin
                tick();
                n++;
            end
            chk("tmo_abort", busy, 0);
        end
        chk("tmo_idle_cycles", cyc - last_act, 15);
        chk("tmo_err", err, 1);
        chk("tmo_m_reset", m_reset, 1);
        chk("tmo_dc_ready", dc_ready, 1);
        chk("tmo_done", done, 0);
        chk("tmo_words", x0, 2);
        tick();
        chk("tmo_m_reset_off", m_reset, 0);
        x0_lim = 1 << 30;
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
